// File: rtl/shift_seq_ctrl.sv
// Sequential one-bit-per-cycle shifter (SLL/SRL/SRA, optional ROR) with IDLE/SHIFT/DONE control.
// Optional feature: define SHIFT_ROR_EN to enable rotate-right on op=11; otherwise op=11 is a pass-through.
module shift_seq_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [1:0]         op,
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 ready_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic [1:0]           op_q;
  logic [DATA_W-1:0]    work;
  logic [DATA_W-1:0]    work_shift_c;
  logic [SHAMT_W-1:0]   cnt;
  logic                 accept_c;
  logic                 pass_c;
  logic                 last_c;

  assign accept_c = (state == IDLE) && start_valid && !flush;
  assign last_c   = (state == SHIFT) && (cnt == SHAMT_W'(1));

  // Operations that complete on the accepting edge with result = a.
`ifdef SHIFT_ROR_EN
  assign pass_c = (shamt == '0);
`else
  assign pass_c = (shamt == '0) || (op == OP_ROR);
`endif

  // One-bit step of the captured operation.
  always_comb begin
    work_shift_c = work;
    case (op_q)
      OP_SLL: work_shift_c = {work[DATA_W-2:0], 1'b0};
      OP_SRL: work_shift_c = {1'b0, work[DATA_W-1:1]};
      OP_SRA: work_shift_c = {work[DATA_W-1], work[DATA_W-1:1]};
`ifdef SHIFT_ROR_EN
      OP_ROR: work_shift_c = {work[0], work[DATA_W-1:1]};
`endif
      default: work_shift_c = work;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides everything except reset.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            state_nxt = pass_c ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          if (last_c) begin
            state_nxt = DONE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so the status flops line up with the state register.
  always_comb begin
    ready_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state_nxt)
      IDLE:    ready_nxt = 1'b1;
      SHIFT:   busy_nxt  = 1'b1;
      DONE: begin
        busy_nxt = 1'b1;
        done_nxt = 1'b1;
      end
      default: ready_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      start_ready <= ready_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

  // Datapath: capture on accept, shift in SHIFT, load result only on DONE entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= 2'b00;
      work   <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (!flush) begin
      if (accept_c) begin
        op_q <= op;
        work <= a;
        cnt  <= shamt;
        if (pass_c) begin
          result <= a;
        end
      end else if (state == SHIFT) begin
        work <= work_shift_c;
        cnt  <= cnt - SHAMT_W'(1);
        if (last_c) begin
          result <= work_shift_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed + scoreboard bench for shift_seq_ctrl; honours SHIFT_ROR_EN the same way as the design.
module tb_shift_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  op;
  logic [15:0] a;
  logic [3:0]  shamt;
  logic        flush;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int checks;
  int errors;
  logic [15:0] exp_q[$];

  shift_seq_ctrl #(.DATA_W(16), .SHAMT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op          (op),
    .a           (a),
    .shamt       (shamt),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result written with whole-word operators.
  function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] av, input logic [3:0] s);
    logic [15:0] r;
    case (o)
      2'b00: r = av << s;
      2'b01: r = av >> s;
      2'b10: r = 16'($signed(av) >>> s);
`ifdef SHIFT_ROR_EN
      default: r = (s == 4'd0) ? av : ((av >> s) | (av << (16 - int'(s))));
`else
      default: r = av;
`endif
    endcase
    return r;
  endfunction

  // Present one operation at a falling edge; it is accepted on the following rising edge.
  task automatic drive_accept(input logic [1:0] o, input logic [15:0] av, input logic [3:0] s,
                              input bit track, input logic [15:0] exp);
    check("ready_before_accept", start_ready, 1);
    start_valid = 1'b1;
    op = o;
    a = av;
    shamt = s;
    if (track) exp_q.push_back(exp);
    @(negedge clk);
    start_valid = 1'b0;
    op = 2'($urandom);
    a = 16'($urandom);
    shamt = 4'($urandom);
  endtask

  // Wait for done after an accept, checking latency, busy length, result and the one-cycle pulse.
  task automatic expect_done(input int lat);
    int n;
    int nb;
    logic [15:0] exp;
    n = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    if (busy) nb++;
    check("done_latency", n, lat);
    check("busy_cycles", nb, lat + 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check("done_seen", done, 1);
    check("result", result, exp);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("ready_after_done", start_ready, 1);
    check("result_held", result, exp);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [15:0] ra;
    logic [3:0]  rs;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start_valid = 1'b1;
    op = 2'b00;
    a = 16'hFFFF;
    shamt = 4'd0;
    flush = 1'b0;

    // Reset holds priority over a pending start.
    repeat (2) @(negedge clk);
    check("rst_ready", start_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 16'h0000);

    // First accept on the first edge with rst_n high.
    rst_n = 1'b1;
    start_valid = 1'b0;
    drive_accept(2'b10, 16'h8000, 4'd3, 1'b1, 16'hF000);
    expect_done(3);

    // Zero shift then back-to-back SRL.
    drive_accept(2'b00, 16'h1234, 4'd0, 1'b1, 16'h1234);
    expect_done(0);
    drive_accept(2'b01, 16'h1234, 4'd4, 1'b1, 16'h0123);
    expect_done(4);

    // Flush mid-run: no done, result unchanged.
    drive_accept(2'b01, 16'h00F0, 4'd8, 1'b0, 16'h0000);
    repeat (3) begin
      check("flush_no_done_pre", done, 0);
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_no_done", done, 0);
    check("flush_busy", busy, 0);
    check("flush_ready", start_ready, 1);
    check("flush_result", result, 16'h0123);

    // Flush together with start_valid in IDLE: no accept.
    flush = 1'b1;
    start_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start_valid = 1'b0;
    check("flush_wins_ready", start_ready, 1);
    check("flush_wins_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("flush_wins_done", done, 0);

    // op=11 behaviour depends on the build option.
`ifdef SHIFT_ROR_EN
    drive_accept(2'b11, 16'h0001, 4'd1, 1'b1, 16'h8000);
    expect_done(1);
`else
    drive_accept(2'b11, 16'h0001, 4'd1, 1'b1, 16'h0001);
    expect_done(0);
`endif

    // Reset mid-run of a maximum-length SRA.
    drive_accept(2'b10, 16'hFFFF, 4'd15, 1'b0, 16'h0000);
    repeat (6) begin
      check("rst_mid_no_done_pre", done, 0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_no_done", done, 0);
    check("rst_mid_result", result, 16'h0000);
    check("rst_mid_ready", start_ready, 1);
    check("rst_mid_busy", busy, 0);

    // Maximum shift amount runs to completion.
    drive_accept(2'b10, 16'hFFFF, 4'd15, 1'b1, 16'hFFFF);
    expect_done(15);
    drive_accept(2'b00, 16'h0001, 4'd15, 1'b1, 16'h8000);
    expect_done(15);
    drive_accept(2'b10, 16'h8001, 4'd15, 1'b1, 16'hFFFF);
    expect_done(15);

    // Random operations against the word-level model.
    for (int i = 0; i < 8; i++) begin
`ifdef SHIFT_ROR_EN
      ro = 2'($urandom_range(0, 3));
`else
      ro = 2'($urandom_range(0, 2));
`endif
      ra = 16'($urandom);
      rs = 4'($urandom_range(0, 15));
      drive_accept(ro, ra, rs, 1'b1, model(ro, ra, rs));
      expect_done(int'(rs));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
